// File: rtl/xaui_pkg.sv
// rtl/xaui_pkg.sv - shared state type and index layout for the XAUI equaliser sweep
package xaui_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_DWELL,
    ST_EVAL,
    ST_DONE
  } sweep_state_t;

  localparam int NUM_COMBOS = 64;
  localparam int IDX_W      = 6;
  localparam int MIX_MSB    = 5;
  localparam int MIX_LSB    = 4;
  localparam int POLE_MSB   = 3;
  localparam int POLE_LSB   = 0;

  localparam logic [7:0] DEF_STATUS_MASK = 8'hFC;

endpackage

// File: rtl/xaui_eq_scorer.sv
// rtl/xaui_eq_scorer.sv - counts status-good cycles while enabled; clear wins over enable
module xaui_eq_scorer #(
  parameter int SCORE_W = 17
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               enable,
  input  logic               good,
  output logic [SCORE_W-1:0] score
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      score <= '0;
    end else if (clear) begin
      score <= '0;
    end else if (enable && good) begin
      score <= score + SCORE_W'(1);
    end
  end

endmodule

// File: rtl/xaui_eq_sweep.sv
// rtl/xaui_eq_sweep.sv - sweeps all rxeqmix/rxeqpole combinations and commits the best-scoring one
module xaui_eq_sweep
  import xaui_pkg::*;
#(
  parameter int         SETTLE_CYCLES = 1024,
  parameter int         DWELL_CYCLES  = 65536,
  parameter int         SCORE_W       = 17,
  parameter logic [7:0] STATUS_MASK   = DEF_STATUS_MASK
) (
  input  logic               OPB_Clk,
  input  logic               OPB_Rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               ovr_en,
  input  logic [1:0]         ovr_rxeqmix,
  input  logic [3:0]         ovr_rxeqpole,
  input  logic [7:0]         xaui_status,
  output logic [1:0]         rxeqmix,
  output logic [3:0]         rxeqpole,
  output logic               busy,
  output logic               done,
  output logic [IDX_W-1:0]   best_idx,
  output logic [SCORE_W-1:0] best_score,
  output logic               sweep_valid
);

  localparam int CNT_MAX = (SETTLE_CYCLES > DWELL_CYCLES) ? SETTLE_CYCLES : DWELL_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  sweep_state_t       state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   cur_idx, best_run_idx, sel_idx;
  logic [SCORE_W-1:0] best_run_score, score;
  logic [7:0]         status_q;
  logic               good, aborting, last_combo, cnt_zero;

  always_ff @(posedge OPB_Clk) begin
    if (!OPB_Rst_n) status_q <= '0;
    else            status_q <= xaui_status;
  end

  assign good       = ((status_q & STATUS_MASK) == STATUS_MASK);
  assign aborting   = abort && (state != ST_IDLE);
  assign last_combo = (cur_idx == IDX_W'(NUM_COMBOS - 1));
  assign cnt_zero   = (cnt == '0);

  always_ff @(posedge OPB_Clk) begin
    if (!OPB_Rst_n) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_APPLY;
      ST_APPLY:  state_nxt = ST_SETTLE;
      ST_SETTLE: if (cnt_zero) state_nxt = ST_DWELL;
      ST_DWELL:  if (cnt_zero) state_nxt = ST_EVAL;
      ST_EVAL:   state_nxt = last_combo ? ST_DONE : ST_APPLY;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
    if (aborting) state_nxt = ST_IDLE;
  end

  xaui_eq_scorer #(.SCORE_W(SCORE_W)) u_scorer (
    .clk    (OPB_Clk),
    .rst_n  (OPB_Rst_n),
    .clear  (state == ST_SETTLE && cnt_zero),
    .enable (state == ST_DWELL),
    .good   (good),
    .score  (score)
  );

  always_ff @(posedge OPB_Clk) begin
    if (!OPB_Rst_n) begin
      cnt            <= '0;
      cur_idx        <= '0;
      best_run_idx   <= '0;
      best_run_score <= '0;
      best_idx       <= '0;
      best_score     <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      sweep_valid    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (aborting) begin
        busy <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: if (start) begin
            busy           <= 1'b1;
            cur_idx        <= '0;
            best_run_idx   <= '0;
            best_run_score <= '0;
          end
          ST_APPLY:  cnt <= CNT_W'(SETTLE_CYCLES - 1);
          ST_SETTLE: cnt <= cnt_zero ? CNT_W'(DWELL_CYCLES - 1) : cnt - CNT_W'(1);
          ST_DWELL:  if (!cnt_zero) cnt <= cnt - CNT_W'(1);
          ST_EVAL: begin
            // strict compare keeps the lowest index on a tie
            if (score > best_run_score) begin
              best_run_score <= score;
              best_run_idx   <= cur_idx;
            end
            if (!last_combo) cur_idx <= cur_idx + IDX_W'(1);
          end
          ST_DONE: begin
            best_idx    <= best_run_idx;
            best_score  <= best_run_score;
            done        <= 1'b1;
            sweep_valid <= 1'b1;
            busy        <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign sel_idx = (state == ST_IDLE) ? best_idx : cur_idx;

  always_ff @(posedge OPB_Clk) begin
    if (!OPB_Rst_n) begin
      rxeqmix  <= '0;
      rxeqpole <= '0;
    end else if (ovr_en) begin
      rxeqmix  <= ovr_rxeqmix;
      rxeqpole <= ovr_rxeqpole;
    end else begin
      rxeqmix  <= sel_idx[MIX_MSB:MIX_LSB];
      rxeqpole <= sel_idx[POLE_MSB:POLE_LSB];
    end
  end

endmodule

// File: doc/xaui_eq_sweep.md
Name: xaui_eq_sweep

Overview:
- Receive-equalisation training controller for the XAUI PHY.
- On a start request it sweeps all 64 {rxeqmix, rxeqpole} combinations. For each one it waits for the receiver to settle, then scores link quality by counting status-good cycles on xaui_status.
- It then commits the best combination to the PHY equaliser inputs.
- Sits between the OPB register block (start, abort, manual override) and the XAUI core's rxeqmix/rxeqpole pins.

Parameters:
- SETTLE_CYCLES, 1024: cycles to wait after applying a setting before scoring starts; must be >= 1.
- DWELL_CYCLES, 65536: scoring window length in cycles; must be >= 1.
- SCORE_W, 17: score counter width; must satisfy 2^SCORE_W > DWELL_CYCLES.
- STATUS_MASK, 8'hFC: status bits that must all be 1 for a cycle to count as good.

Ports:
- OPB_Clk  in  1  sole clock.
- OPB_Rst_n  in  1  synchronous, active-low reset.
- start  in  1  single-cycle pulse that requests a sweep.
- abort  in  1  single-cycle pulse that cancels a sweep in progress.
- ovr_en  in  1  manual override enable.
- ovr_rxeqmix  in  2  override value for rxeqmix.
- ovr_rxeqpole  in  4  override value for rxeqpole.
- xaui_status  in  8  PHY status, already synchronised to OPB_Clk.
- rxeqmix  out  2  equaliser mix setting driven to the PHY.
- rxeqpole  out  4  equaliser pole setting driven to the PHY.
- busy  out  1  high while a sweep is running.
- done  out  1  one-cycle pulse when a sweep completes normally.
- best_idx  out  6  committed combination, encoded {mix[1:0], pole[3:0]}.
- best_score  out  SCORE_W  score of the committed combination.
- sweep_valid  out  1  high once at least one sweep has completed.

Behaviour:
- Reset (OPB_Rst_n=0 at a clock edge; applies mid-sweep as well):
  - state goes to IDLE;
  - cur_idx, best_idx, best_score, counters all 0;
  - busy=0, done=0, sweep_valid=0;
  - rxeqmix=2'b00, rxeqpole=4'b0000.
- Status sampling: xaui_status is registered once before use. good = ((status_q & STATUS_MASK) == STATUS_MASK).
- Output mux, registered:
  - ovr_en=1: outputs follow the ovr_* inputs, one cycle of latency;
  - ovr_en=0, state IDLE: outputs show the committed best_idx;
  - ovr_en=0, sweep running: outputs show cur_idx.
  - ovr_en does not stop a sweep; the sweep still runs and commits, and the result appears once ovr_en drops.
- FSM states: IDLE, APPLY, SETTLE, DWELL, EVAL, DONE.
  - IDLE: start=1 -> APPLY. Set busy=1, cur_idx=0, clear the running best (best_run_score=0, best_run_idx=0).
  - APPLY (1 cycle): present cur_idx to the outputs, load cnt=SETTLE_CYCLES-1 -> SETTLE.
  - SETTLE: decrement cnt. At cnt==0 -> DWELL, with cnt=DWELL_CYCLES-1 and score=0.
  - DWELL: add 1 to score on every cycle with good=1, including the final cycle. At cnt==0 -> EVAL.
  - EVAL (1 cycle):
    - if score > best_run_score (strictly greater), update best_run_score and best_run_idx; on a tie the lowest index wins;
    - if cur_idx==63 -> DONE;
    - otherwise cur_idx+1 -> APPLY.
  - DONE (1 cycle):
    - best_idx <= best_run_idx, best_score <= best_run_score;
    - done=1, sweep_valid=1, busy=0 -> IDLE.
    - If every combination scores 0, best_idx=0 and best_score=0 are committed.
- Per-combination latency: SETTLE_CYCLES + DWELL_CYCLES + 2 cycles.
- Sweep latency from start to done: 1 + 64*(SETTLE_CYCLES + DWELL_CYCLES + 2) cycles.
- start while busy=1: ignored; no restart.
- abort while busy=1: next state IDLE, busy=0, no done pulse. best_idx, best_score and sweep_valid keep their previous values, so the outputs revert to the last committed setting.
- abort while idle: no effect.
- start and abort asserted in the same IDLE cycle: start wins.
- start and abort asserted in the same busy cycle: abort wins.
- Score arithmetic: unsigned, cannot overflow given the SCORE_W constraint.

Decomposition:
- Shared package xaui_pkg holds:
  - the state enum;
  - NUM_COMBOS=64;
  - field positions of idx (MIX_MSB=5, MIX_LSB=4, POLE_MSB=3, POLE_LSB=0);
  - the default STATUS_MASK.
- One sub-module is natural: xaui_eq_scorer. It takes clear/enable and good, and returns score. It is reusable for monitoring a single setting.

Test Plan (SETTLE_CYCLES=4, DWELL_CYCLES=8, SCORE_W=4 unless noted):
- Reset: hold OPB_Rst_n=0 with xaui_status=8'hFF -> rxeqmix=0, rxeqpole=0, busy=0, sweep_valid=0. start during reset is ignored.
- Single peak: status is good only while the outputs equal idx 0x25 (mix=2, pole=5) -> done after exactly 1+64*14=897 cycles; best_idx=6'h25, best_score=8; the outputs show mix=2, pole=5.
- Tie: idx 0x10 and idx 0x30 both score 8 -> best_idx=6'h10.
- Abort mid-sweep: after a first sweep commits 0x25, start again, pulse abort at cycle 300 -> busy=0, no done pulse, outputs return to mix=2, pole=5, best_idx stays 0x25.
- Override: ovr_en=1 with ovr=(3, 4'hA) during a sweep -> outputs read 3/A one cycle later. The sweep still completes with done=1; after ovr_en=0 the committed best is shown.
- Busy start and all-bad sweep: pulse start while busy -> no restart, total latency stays 897. A separate sweep with xaui_status=8'h00 throughout -> best_idx=0, best_score=0, sweep_valid=1.
